hazard_stall_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage ARMv8 pipeline. It generates the Stall inputs consumed by the PC and pipeline registers, plus bubble and flush controls. It detects load-use hazards in ID, holds the whole pipeline while data memory is busy, and flushes the front stages on a taken branch resolved in MEM. A memory-wait watchdog FSM and two saturating performance counters supply the sequential behaviour.

---
 rtl/hazard_stall_ctrl_pkg.sv | 31 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 24 ++
 rtl/hazard_stall_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    // Memory-wait watchdog states.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } wd_state_e;

    // Reason driving the pipeline controls this cycle, highest priority first.
    typedef enum logic [2:0] {
        CAUSE_ERROR    = 3'd0,
        CAUSE_MEM_BUSY = 3'd1,
        CAUSE_BRANCH   = 3'd2,
        CAUSE_LOAD_USE = 3'd3,
        CAUSE_NONE     = 3'd4
    } ctrl_cause_e;

    // Pipeline control bundle.
    typedef struct packed {
        logic stall_front;
        logic stall_back;
        logic bubble_idex;
        logic flush_front;
    } ctrl_s;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and async active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: load-use bubbles, memory-busy holds,
// branch flushes, a memory-wait watchdog and stall/bubble counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rd,
    input  logic [REG_W-1:0] IFID_Rn,
    input  logic [REG_W-1:0] IFID_Rm,
    input  logic             IFID_UsesRn,
    input  logic             IFID_UsesRm,
    input  logic             Mem_Busy,
    input  logic             Branch_Taken,
    output logic             Stall_Front,
    output logic             Stall_Back,
    output logic             Bubble_IDEX,
    output logic             Flush_Front,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Bubble_Count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);

    wd_state_e          state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               load_use;
    ctrl_cause_e        cause;
    ctrl_s              ctrl;

    // Load in EX writing a register that ID actually reads; XZR never hazards.
    assign load_use = IDEX_MemRead && (IDEX_Rd != XZR) &&
                      ((IFID_UsesRn && (IFID_Rn == IDEX_Rd)) ||
                       (IFID_UsesRm && (IFID_Rm == IDEX_Rd)));

    // Watchdog state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Watchdog next state: trips at the end of the TIMEOUT-th consecutive busy cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (Mem_Busy) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!Mem_Busy) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline controls by priority; a branch pending under Mem_Busy waits in EX/MEM.
    always_comb begin
        cause = CAUSE_NONE;
        ctrl  = '0;
        if (state_q == ST_ERROR) begin
            cause = CAUSE_ERROR;
        end else if (Mem_Busy) begin
            cause = CAUSE_MEM_BUSY;
        end else if (Branch_Taken) begin
            cause = CAUSE_BRANCH;
        end else if (load_use) begin
            cause = CAUSE_LOAD_USE;
        end
        if (Reset) begin
            case (cause)
                CAUSE_ERROR, CAUSE_MEM_BUSY: begin
                    ctrl.stall_front = 1'b1;
                    ctrl.stall_back  = 1'b1;
                end
                CAUSE_BRANCH: begin
                    ctrl.flush_front = 1'b1;
                end
                CAUSE_LOAD_USE: begin
                    ctrl.stall_front = 1'b1;
                    ctrl.bubble_idex = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

    assign Stall_Front = ctrl.stall_front;
    assign Stall_Back  = ctrl.stall_back;
    assign Bubble_IDEX = ctrl.bubble_idex;
    assign Flush_Front = ctrl.flush_front;
    assign Mem_Error   = (state_q == ST_ERROR);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .en_i    (ctrl.stall_front),
        .count_o (Stall_Count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .en_i    (ctrl.bubble_idex),
        .count_o (Bubble_Count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          Reset;
    logic          IDEX_MemRead;
    logic [4:0]    IDEX_Rd, IFID_Rn, IFID_Rm;
    logic          IFID_UsesRn, IFID_UsesRm;
    logic          Mem_Busy, Branch_Taken;
    logic          Stall_Front, Stall_Back, Bubble_IDEX, Flush_Front, Mem_Error;
    logic [CW-1:0] Stall_Count, Bubble_Count;

    int n_total = 0;
    int n_pass  = 0;

    hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_Rd      (IDEX_Rd),
        .IFID_Rn      (IFID_Rn),
        .IFID_Rm      (IFID_Rm),
        .IFID_UsesRn  (IFID_UsesRn),
        .IFID_UsesRm  (IFID_UsesRm),
        .Mem_Busy     (Mem_Busy),
        .Branch_Taken (Branch_Taken),
        .Stall_Front  (Stall_Front),
        .Stall_Back   (Stall_Back),
        .Bubble_IDEX  (Bubble_IDEX),
        .Flush_Front  (Flush_Front),
        .Mem_Error    (Mem_Error),
        .Stall_Count  (Stall_Count),
        .Bubble_Count (Bubble_Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit lu_f(input bit mr, input int rd, input int rn, input int rm,
                                input bit urn, input bit urm);
        if (!mr || rd == 31) return 1'b0;
        return (urn && rn == rd) || (urm && rm == rd);
    endfunction

    // {front, back, bubble, flush}
    function automatic logic [3:0] exp_f(input bit err, input bit busy, input bit br, input bit lu);
        if (err || busy) return 4'b1100;
        if (br)          return 4'b0001;
        if (lu)          return 4'b1010;
        return 4'b0000;
    endfunction

    int   m_run, m_stall, m_bub;
    bit   m_err;
    logic [3:0] e_now;

    assign e_now = exp_f(m_err, Mem_Busy, Branch_Taken,
                         lu_f(IDEX_MemRead, int'(IDEX_Rd), int'(IFID_Rn), int'(IFID_Rm),
                              IFID_UsesRn, IFID_UsesRm));

    // Model advances on each clock edge; reset clears it asynchronously.
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            m_run <= 0; m_err <= 1'b0; m_stall <= 0; m_bub <= 0;
        end else begin
            if (e_now[3] && m_stall < CMAX) m_stall <= m_stall + 1;
            if (e_now[1] && m_bub < CMAX)   m_bub   <= m_bub + 1;
            if (!m_err) begin
                if (Mem_Busy) begin
                    m_run <= m_run + 1;
                    if (m_run + 1 == TO) m_err <= 1'b1;
                end else begin
                    m_run <= 0;
                end
            end
        end
    end

    // Per-cycle compare, mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (Reset) begin
            chk("stall_front", int'(Stall_Front), int'(e_now[3]));
            chk("stall_back",  int'(Stall_Back),  int'(e_now[2]));
            chk("bubble_idex", int'(Bubble_IDEX), int'(e_now[1]));
            chk("flush_front", int'(Flush_Front), int'(e_now[0]));
            chk("mem_error",   int'(Mem_Error),   int'(m_err));
            chk("stall_count", int'(Stall_Count), m_stall);
            chk("bubble_count",int'(Bubble_Count),m_bub);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit mr, input int rd, input int rn, input int rm,
                         input bit urn, input bit urm, input bit busy, input bit br);
        IDEX_MemRead = mr;  IDEX_Rd = 5'(rd); IFID_Rn = 5'(rn); IFID_Rm = 5'(rm);
        IFID_UsesRn  = urn; IFID_UsesRm = urm; Mem_Busy = busy; Branch_Taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reset pulse away from clock edges, with active inputs to prove outputs are forced low.
    task automatic do_reset();
        Reset = 1'b0;
        drive(1, 3, 3, 3, 1, 1, 1, 1);
        #1;
        chk("rst_front", int'(Stall_Front), 0);
        chk("rst_back",  int'(Stall_Back),  0);
        chk("rst_bub",   int'(Bubble_IDEX), 0);
        chk("rst_flush", int'(Flush_Front), 0);
        chk("rst_err",   int'(Mem_Error),   0);
        chk("rst_scnt",  int'(Stall_Count), 0);
        chk("rst_bcnt",  int'(Bubble_Count),0);
        idle();
        #1 Reset = 1'b1;
    endtask

    function automatic int rnd_reg();
        int k = int'($urandom_range(0, 4));
        return (k == 4) ? 31 : k;
    endfunction

    initial begin
        Reset = 1'b0;
        idle();
        do_reset();
        tick();

        // Load-use: one-cycle stall + bubble.
        drive(1, 3, 3, 0, 1, 0, 0, 0);
        #1;
        chk("lu_front", int'(Stall_Front), 1);
        chk("lu_bub",   int'(Bubble_IDEX), 1);
        chk("lu_back",  int'(Stall_Back),  0);
        tick(); idle();
        chk("lu_bcnt", int'(Bubble_Count), 1);
        chk("lu_scnt", int'(Stall_Count),  1);

        // XZR destination and unused operand never stall.
        drive(1, 31, 31, 0, 1, 0, 0, 0);
        #1;
        chk("xzr_front", int'(Stall_Front), 0);
        chk("xzr_bub",   int'(Bubble_IDEX), 0);
        tick();
        drive(1, 5, 0, 5, 0, 0, 0, 0);
        #1;
        chk("unused_front", int'(Stall_Front), 0);
        chk("unused_bub",   int'(Bubble_IDEX), 0);
        tick(); idle();

        // Three busy cycles.
        do_reset(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            #1;
            chk("busy_front", int'(Stall_Front), 1);
            chk("busy_back",  int'(Stall_Back),  1);
            tick();
        end
        idle();
        chk("busy_scnt", int'(Stall_Count), 3);
        chk("busy_err",  int'(Mem_Error),   0);
        tick();

        // Branch beats load-use.
        drive(1, 3, 3, 0, 1, 0, 0, 1);
        #1;
        chk("br_flush", int'(Flush_Front), 1);
        chk("br_front", int'(Stall_Front), 0);
        chk("br_bub",   int'(Bubble_IDEX), 0);
        tick();
        // Branch held under two busy cycles, flushes once memory is ready.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 1);
            #1;
            chk("brbusy_front", int'(Stall_Front), 1);
            chk("brbusy_flush", int'(Flush_Front), 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("brrel_flush", int'(Flush_Front), 1);
        chk("brrel_front", int'(Stall_Front), 0);
        tick(); idle();

        // Watchdog trips on the 4th busy edge and stays sticky.
        do_reset(); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("wd_err_pre", int'(Mem_Error), 0);
            tick();
        end
        chk("wd_err", int'(Mem_Error), 1);
        idle();
        #1;
        chk("wd_front", int'(Stall_Front), 1);
        chk("wd_back",  int'(Stall_Back),  1);
        tick();
        chk("wd_sticky", int'(Mem_Error), 1);
        chk("wd_scnt",   int'(Stall_Count), 5);
        // Async reset mid-cycle clears immediately.
        #1 Reset = 1'b0;
        #1;
        chk("arst_err",   int'(Mem_Error),   0);
        chk("arst_front", int'(Stall_Front), 0);
        chk("arst_scnt",  int'(Stall_Count), 0);
        Reset = 1'b1;
        tick();

        // Saturation after 20 load-use cycles.
        do_reset(); tick();
        drive(1, 2, 0, 2, 0, 1, 0, 0);
        repeat (20) tick();
        idle();
        chk("sat_scnt", int'(Stall_Count),  15);
        chk("sat_bcnt", int'(Bubble_Count), 15);
        tick();

        // Randomized traffic against the model, with periodic resets.
        for (int c = 0; c < 2000; c++) begin
            if (c % 150 == 149) do_reset();
            drive(($urandom_range(0, 1) == 1), rnd_reg(), rnd_reg(), rnd_reg(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
